// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external combinational ALU between two requesters.
// Each operation runs IDLE (grant) -> EXEC (capture) -> RESP (hold until rsp_ready).
`default_nettype none

module alu_arbiter #(
    parameter int W  = 4,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [W-1:0]  a0,
    input  logic [W-1:0]  b0,
    input  logic [W-1:0]  a1,
    input  logic [W-1:0]  b1,
    input  logic [SW-1:0] sel0,
    input  logic [SW-1:0] sel1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [SW-1:0] alu_sel,
    input  logic [W-1:0]  alu_out,
    output logic          rsp_valid,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_id,
    input  logic          rsp_ready,
    output logic          busy,
    output logic [7:0]    op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   ptr;
    logic   win_idx;
    logic   any_req;
    logic   winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are combinational so they cover only the IDLE cycle of the win;
    // rst_n gating keeps them low while reset is held.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        any_req   = req0 | req1;
        winner    = (req0 && req1) ? ptr : req1;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = EXEC;
                    gnt0      = rst_n & ~winner;
                    gnt1      = rst_n & winner;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            win_idx   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            op_cnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        alu_a   <= winner ? a1 : a0;
                        alu_b   <= winner ? b1 : b0;
                        alu_sel <= winner ? sel1 : sel0;
                        win_idx <= winner;
                        ptr     <= ~winner;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_id    <= win_idx;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_cnt    <= op_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, 4, operand/result width.
REQ-002 Parameter: SW, 3, opcode (sel) width.
REQ-003 Clocking SHALL be one clock with asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0 / req1  input  1  request from requester 0 / 1.
REQ-007 a0, b0 / a1, b1  input  W  operands of requester 0 / 1.
REQ-008 sel0 / sel1  input  SW  opcode of requester 0 / 1.
REQ-009 gnt0 / gnt1  output  1  one-cycle grant pulse to requester 0 / 1.
REQ-010 alu_a, alu_b  output  W  registered operands to the shared ALU.
REQ-011 alu_sel  output  SW  registered opcode to the shared ALU.
REQ-012 alu_out  input  W  combinational result from the shared ALU.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_data  output  W  captured ALU result.
REQ-015 rsp_id  output  1  requester index owning the response.
REQ-016 rsp_ready  input  1  consumer accepts the response.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 op_cnt  output  8  completed-operation counter.

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-020 In IDLE with any req high, the FSM SHALL grant exactly one requester, latch that requester's a/b/sel into alu_a/alu_b/alu_sel, record its index, and move to EXEC on the next edge.
REQ-021 Arbitration SHALL be round-robin via a 1-bit priority pointer: the pointed-to requester wins ties; a sole requester wins regardless of the pointer.
REQ-022 After each grant the pointer SHALL move to the non-winning index.
REQ-023 gntN SHALL be high for exactly the IDLE cycle in which requester N wins, and never in EXEC or RESP.
REQ-024 Requesters SHALL hold req and operands stable until granted; req asserted outside IDLE SHALL be ignored, with no queuing beyond the level-held req.
REQ-025 In EXEC (one cycle), alu_out SHALL be captured into rsp_data, rsp_id set to the winner, and the FSM SHALL move to RESP.
REQ-026 In RESP, rsp_valid SHALL be 1 with rsp_data/rsp_id stable until the cycle in which rsp_ready is 1.
REQ-027 On that cycle the FSM SHALL move to IDLE, rsp_valid SHALL deassert on the next edge, and op_cnt SHALL increment.
REQ-028 op_cnt SHALL wrap 255 -> 0.
REQ-029 alu_a/alu_b/alu_sel SHALL hold their last latched values in IDLE and RESP.
REQ-030 Latency from grant to rsp_valid SHALL be 2 cycles; maximum throughput SHALL be one operation per 3 cycles.
REQ-031 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-032 rsp_data SHALL be exactly W bits; the block SHALL perform no arithmetic on data.

Reset
REQ-033 rst_n low SHALL immediately force, regardless of clk: state=IDLE, pointer=0, gnt0/gnt1=0, alu_a/alu_b/alu_sel=0, rsp_valid=0, rsp_data=0, rsp_id=0, op_cnt=0, busy=0.
REQ-034 Reset asserted in EXEC or RESP SHALL abort the operation: no response, no op_cnt increment.
REQ-035 The first cycle after reset release SHALL be a normal IDLE cycle.

Verification
(ALU stub for all scenarios: alu_out = alu_a XOR alu_b.)
REQ-036 Single request: req0=1, a0=0001, b0=1101, sel0=001, rsp_ready=1 -> gnt0 pulse; alu_sel=001 in EXEC; rsp_valid after 2 cycles with rsp_data=1100, rsp_id=0; op_cnt=1.
REQ-037 Contention: req0=req1=1 held continuously, rsp_ready=1 -> grant order 0,1,0,1; rsp_id alternates; gnt0 and gnt1 are never high together.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles in RESP (a1=0011, b1=1001) -> rsp_valid held, rsp_data=1010 stable, busy=1, req0 not granted; rsp_ready=1 -> IDLE next cycle.
REQ-039 Reset mid-operation: rst_n low during EXEC -> all outputs at reset values immediately; no response after release; op_cnt=0.
REQ-040 Counter wrap: 256 back-to-back operations -> op_cnt returns to 0.
REQ-041 Pointer persistence: req1 alone, then req0 and req1 together -> requester 0 wins the second arbitration.
